// File: rtl/my_uart_pkg.sv
// Shared UART definitions: default bit timing, frame shape and receiver FSM states.
// Used by uart_rx_os16 and uart_baud_tick.
package my_uart_pkg;

    // Default clk cycles per 1/16 bit tick (8'd163)
    localparam int unsigned UART_CLK_DIV_DEF    = 163;
    localparam int unsigned UART_NUM_DWORD_BITS = 8;
    localparam int unsigned UART_NUM_STOP_BITS  = 1;
    localparam int unsigned UART_OS_RATE        = 16;
    localparam int unsigned UART_OS_MID         = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..CLK_DIV-1 and pulses tick_o on the wrap cycle.
// clr_i restarts the count so the tick phase can be aligned to an incoming frame.
module uart_baud_tick #(
    parameter int unsigned CLK_DIV = 163
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling 8N1 UART receiver with a valid/ready byte output.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os16
    import my_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = UART_CLK_DIV_DEF,
    parameter int unsigned DATA_BITS = UART_NUM_DWORD_BITS,
    parameter int unsigned STOP_BITS = UART_NUM_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    logic                 tick, tick_clr;
    uart_rx_state_t       state_q, state_d;
    logic [3:0]           samp_q, samp_d;
    logic [IDX_W-1:0]     bit_q, bit_d;
    logic [1:0]           stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 wait_high_q, wait_high_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 complete;
    logic                 last_samp;
`ifdef UART_RX_PARITY_EN
    logic                 perr_acc_q, perr_acc_d;
    logic                 perr_q, perr_d;
`endif

    assign rx_s = sync2_q;

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tick_clr),
        .tick_o(tick)
    );

    assign last_samp = (samp_q == 4'(UART_OS_RATE - 1));

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        ferr_acc_d  = ferr_acc_q;
        wait_high_d = wait_high_q;
        tick_clr    = 1'b0;
        complete    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_acc_d  = perr_acc_q;
`endif
        case (state_q)
            IDLE: begin
                // After a frame that ended low (break), re-arm only once the line idles high
                if (wait_high_q) begin
                    if (rx_s) begin
                        wait_high_d = 1'b0;
                    end
                end else if (!rx_s) begin
                    state_d    = START;
                    tick_clr   = 1'b1;
                    samp_d     = '0;
                    bit_d      = '0;
                    stop_d     = '0;
                    ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_acc_d = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'(UART_OS_MID - 1)) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            samp_d  = '0;
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (last_samp) begin
                        shift_d[bit_q] = rx_s;
                        if (bit_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + IDX_W'(1);
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (last_samp) begin
                        perr_acc_d = rx_s ^ (^shift_q);
                        state_d    = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (last_samp) begin
                        if (!rx_s) begin
                            ferr_acc_d = 1'b1;
                        end
                        // Leave at mid-stop-bit so the next start edge is caught early
                        if (stop_q == 2'(STOP_BITS - 1)) begin
                            state_d     = IDLE;
                            complete    = 1'b1;
                            wait_high_d = !rx_s;
                        end else begin
                            stop_d = stop_q + 2'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
        // A new byte always wins; an unread old byte is lost and flagged
        if (complete) begin
            data_d  = shift_q;
            ferr_d  = ferr_acc_d;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx_ready_i;
`ifdef UART_RX_PARITY_EN
            perr_d  = perr_acc_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            samp_q      <= '0;
            bit_q       <= '0;
            stop_q      <= '0;
            shift_q     <= '0;
            ferr_acc_q  <= 1'b0;
            wait_high_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc_q  <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            ferr_acc_q  <= ferr_acc_d;
            wait_high_q <= wait_high_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_acc_q  <= perr_acc_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at CLK_DIV=4 (64 clk per bit): frame table plus
// glitch, break, overrun and mid-frame reset sequences.
module tb_uart_rx_os16;

    localparam int BIT_T = 64;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 35 + BIT_T * 10;
`else
    localparam int LAT = 35 + BIT_T * 9;
`endif

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;
    logic       busy_o;

    uart_rx_os16 #(
        .CLK_DIV  (4),
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int n_frames = 0;
    int valid_cycles = 0;
    int n_ovr    = 0;
    int cap_cyc  = 0;
    logic [7:0] cap_data = 8'h00;
    logic cap_ferr = 1'b0;
    logic cap_perr = 1'b0;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rx_valid_o === 1'b1) valid_cycles = valid_cycles + 1;
        if (overrun_o === 1'b1) n_ovr = n_ovr + 1;
        if (rx_valid_o === 1'b1 && !valid_prev) begin
            n_frames = n_frames + 1;
            cap_data = rx_data_o;
            cap_ferr = frame_err_o;
            cap_perr = parity_err_o;
            cap_cyc  = cyc;
        end
        valid_prev = (rx_valid_o === 1'b1);
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        logic       par_ok;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at 1 time unit after a rising edge
    task automatic hold(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the line at the stop value
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_ok);
        logic [10:0] frame;
        frame = {stop_v, (par_ok ? ^d : ~(^d)), d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 9; i++) hold(frame[i], BIT_T);
`ifdef UART_RX_PARITY_EN
        hold(frame[9], BIT_T);
`endif
        hold(frame[10], BIT_T);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int v0;
        int o0;
        logic exp_perr;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0};

        rst = 1'b1;
        rx_i = 1'b1;
        rx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(rx_valid_o), 32'd0);
        check("reset_data", 32'(rx_data_o), 32'd0);
        check("reset_ferr", 32'(frame_err_o), 32'd0);
        check("reset_perr", 32'(parity_err_o), 32'd0);
        check("reset_ovr", 32'(overrun_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        align();
        hold(1'b1, 20);

        for (int i = 0; i < 8; i++) begin
            f0 = n_frames;
            v0 = valid_cycles;
            send_frame(vecs[i].data, vecs[i].stop_v, vecs[i].par_ok);
            hold(1'b1, BIT_T);
`ifdef UART_RX_PARITY_EN
            exp_perr = !vecs[i].par_ok;
`else
            exp_perr = 1'b0;
`endif
            check($sformatf("vec%0d_frames", i), 32'(n_frames - f0), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(cap_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), 32'(cap_ferr), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_perr", i), 32'(cap_perr), 32'(exp_perr));
            check($sformatf("vec%0d_valid_width", i), 32'(valid_cycles - v0), 32'd1);
            if (i == 0) check("latency", 32'(cap_cyc - start_cyc), 32'(LAT));
        end

        // False start: 16 clk low glitch
        f0 = n_frames;
        hold(1'b0, 16);
        rx_i = 1'b1;
        @(negedge clk);
        check("glitch_busy", 32'(busy_o), 32'd1);
        align();
        hold(1'b1, BIT_T);
        check("glitch_idle", 32'(busy_o), 32'd0);
        check("glitch_frames", 32'(n_frames - f0), 32'd0);
        send_frame(8'hA3, 1'b1, 1'b1);
        hold(1'b1, BIT_T);
        check("glitch_next_frames", 32'(n_frames - f0), 32'd1);
        check("glitch_next_data", 32'(cap_data), 32'hA3);

        // Stop bit low, then line held low: exactly one frame until the line goes high
        f0 = n_frames;
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (1500) @(posedge clk);
        #1;
        check("break_frames", 32'(n_frames - f0), 32'd1);
        check("break_data", 32'(cap_data), 32'h3C);
        check("break_ferr", 32'(cap_ferr), 32'd1);
        check("break_busy", 32'(busy_o), 32'd0);
        hold(1'b1, BIT_T);
        send_frame(8'h5A, 1'b1, 1'b1);
        hold(1'b1, BIT_T);
        check("break_recover_data", 32'(cap_data), 32'h5A);
        check("break_recover_ferr", 32'(cap_ferr), 32'd0);

        // Overrun: two bytes while the consumer is stalled
        rx_ready_i = 1'b0;
        o0 = n_ovr;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        hold(1'b1, BIT_T);
        check("ovr_pulses", 32'(n_ovr - o0), 32'd1);
        check("ovr_valid", 32'(rx_valid_o), 32'd1);
        check("ovr_data", 32'(rx_data_o), 32'h22);
        rx_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_accept_valid", 32'(rx_valid_o), 32'd0);
        align();

        // Reset in the middle of data bit 4 of 0xF0
        hold(1'b0, BIT_T);
        for (int i = 0; i < 4; i++) hold(1'b0, BIT_T);
        hold(1'b1, 32);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_valid", 32'(rx_valid_o), 32'd0);
        check("midrst_data", 32'(rx_data_o), 32'd0);
        check("midrst_ferr", 32'(frame_err_o), 32'd0);
        check("midrst_ovr", 32'(overrun_o), 32'd0);
        align();
        f0 = n_frames;
        hold(1'b1, BIT_T * 5);
        check("midrst_noframe", 32'(n_frames - f0), 32'd0);
        send_frame(8'h81, 1'b1, 1'b1);
        hold(1'b1, BIT_T);
        check("midrst_next_frames", 32'(n_frames - f0), 32'd1);
        check("midrst_next_data", 32'(cap_data), 32'h81);
        check("midrst_next_ferr", 32'(cap_ferr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
